// File: rtl/sumador_serie.sv
// Multi-cycle adder/subtractor: one SLICE-bit chunk per enabled clock, carry held in a register.
// Optional OVF output when SUMADOR_SERIE_OVF_EN is defined.
module sumador_serie #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             ENB,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [1:0]       MODO,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             BUSY,
   output logic             DONE
`ifdef SUMADOR_SERIE_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int NSLICES = WIDTH / SLICE;
   localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   if ((WIDTH % SLICE) != 0 || SLICE < 1 || SLICE > WIDTH) begin : g_param_chk
      $error("sumador_serie: WIDTH must be a non-zero multiple of SLICE");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             r_state;
   logic               r_rst_meta, r_rst_sync;
   logic [WIDTH-1:0]   r_a, r_b, r_sum;
   logic               r_c, r_sub;
   logic [CW-1:0]      r_cnt;
   logic [SLICE-1:0]   w_a_k, w_b_k, w_s;
   logic               w_c, w_last;
   logic [WIDTH+SLICE-1:0] w_cat;
   logic [WIDTH-1:0]   w_sum_nxt;

   // Reset asserts asynchronously but is released on a clock edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   // Operands shift right each slice; finished sum bits enter from the top.
   assign w_a_k           = r_a[SLICE-1:0];
   assign w_b_k           = r_b[SLICE-1:0];
   assign {w_c, w_s}      = {1'b0, w_a_k} + {1'b0, w_b_k} + {{SLICE{1'b0}}, r_c};
   assign w_cat           = {w_s, r_sum};
   assign w_sum_nxt       = w_cat[WIDTH+SLICE-1:SLICE];
   assign w_last          = (r_cnt == CW'(NSLICES - 1));

`ifdef SUMADOR_SERIE_OVF_EN
   logic w_msb_cin;
   assign w_msb_cin = w_a_k[SLICE-1] ^ w_b_k[SLICE-1] ^ w_s[SLICE-1];
`endif

   always_ff @(posedge CLK or negedge r_rst_sync) begin
      if (!r_rst_sync) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_c     <= 1'b0;
         r_sub   <= 1'b0;
         r_cnt   <= '0;
         Q       <= '0;
         RCO     <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
         OVF     <= 1'b0;
`endif
      end else if (ENB) begin
         case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_a   <= A;
                  r_cnt <= '0;
                  r_sub <= (MODO == 2'b01);
                  case (MODO)
                     2'b00: begin
                        r_b <= B;
                        r_c <= Cin;
                     end
                     2'b01: begin
                        r_b <= ~B;
                        r_c <= ~Cin;
                     end
                     2'b10: begin
                        r_b <= '0;
                        r_c <= 1'b1;
                     end
                     default: begin
                        Q   <= '0;
                        RCO <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
                        OVF <= 1'b0;
`endif
                     end
                  endcase
                  if (MODO == 2'b11) begin
                     r_state <= S_DONE;
                     DONE    <= 1'b1;
                  end else begin
                     r_state <= S_BUSY;
                     BUSY    <= 1'b1;
                  end
               end
            end
            S_BUSY: begin
               r_a   <= r_a >> SLICE;
               r_b   <= r_b >> SLICE;
               r_sum <= w_sum_nxt;
               r_c   <= w_c;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  Q       <= w_sum_nxt;
                  RCO     <= w_c ^ r_sub;
`ifdef SUMADOR_SERIE_OVF_EN
                  OVF     <= w_msb_cin ^ w_c;
`endif
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               DONE    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
